motor_sequencer: RTL
====================

# motor_sequencer

Run-state controller that sits in front of `motor_control_top` and drives its command inputs: PWM command, power level, brake, reverse and the speed-meter time base. It slews the PWM command toward a target at a programmable rate. It enforces a safe direction change by ramping down, braking until the measured speed falls below a threshold, and only then re-starting in the new direction.

## Interface
- `K_PWMRES`, 10, PWM command resolution (matches `motor_control_top`)
- `K_TBDIV`, 16, width of the time-base divider
- `K_SPDWIDTH`, 15, width of measured speed
- `i_clk` in 1 — master clock
- `i_rst_n` in 1 — asynchronous, active-low reset
- `i_enable` in 1 — run request (level)
- `i_target_reverse` in 1 — requested direction
- `i_target_pwm` in K_PWMRES — requested PWM command
- `i_param_tb_div` in K_TBDIV — time-base period minus 1, in clocks
- `i_param_ramp_step` in K_PWMRES — PWM change per tick; 0 = no slew
- `i_param_pwr_level` in 4 — power command while driving, 0..10
- `i_param_stop_thr` in K_SPDWIDTH — speed below which the motor counts as stopped
- `i_param_brake_timeout` in 8 — maximum BRAKE duration, in ticks
- `i_speed` in K_SPDWIDTH — measured speed
- `i_speed_valid` in 1 — `i_speed` sample strobe
- `o_speed_time_base` out 1 — one-cycle tick pulse
- `o_pwm_command` out K_PWMRES — PWM command
- `o_pwr_command` out 4 — power command
- `o_brake` out 1 — brake request
- `o_reverse` out 1 — latched applied direction
- `o_running` out 1 — high in RUN only
- `o_state` out 3 — IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, BRAKE=4
- `o_brake_timeout` out 1 — sticky flag: BRAKE exited by timeout

## Operation
- **Time base**
  - Counter increments every clock.
  - When count >= `i_param_tb_div`: wrap to 0 and assert the internal tick for that cycle.
  - `o_speed_time_base` is the tick, registered.
  - The internal tick drives all slew and timeout updates.
- **IDLE**
  - Outputs: pwm=0, pwr=0, brake=1.
  - `i_enable`=1: latch `o_reverse` ← `i_target_reverse`, clear `o_brake_timeout`, go to RAMP_UP.
- **RAMP_UP / RUN**
  - Outputs: brake=0, pwr=`i_param_pwr_level`.
  - On each tick, pwm moves toward `i_target_pwm` by `i_param_ramp_step`, clamped so it never overshoots the target.
  - Step 0 means pwm = target on the tick.
  - RAMP_UP → RUN when pwm == target; this is checked every cycle, not only on ticks.
  - RUN keeps tracking the target in both directions at the same slew rate.
- **Exit to RAMP_DOWN**
  - From RAMP_UP or RUN when `i_enable`=0 or `i_target_reverse` != `o_reverse`.
  - This exit has priority over a slew update in the same cycle.
- **RAMP_DOWN**
  - Outputs: brake=0, pwr kept at level.
  - On each tick, pwm decreases by step, saturating at 0; step 0 gives pwm=0 on the tick.
  - pwm == 0 → BRAKE, clear the timeout counter.
  - Re-enable with the same direction during RAMP_DOWN is ignored; the sequence completes through BRAKE and IDLE.
- **BRAKE**
  - Outputs: brake=1, pwm=0, pwr=0.
  - `i_speed_valid`=1 with `i_speed` < `i_param_stop_thr` (strict) → IDLE.
  - Otherwise the timeout counter increments on each tick. Reaching `i_param_brake_timeout` → IDLE and set `o_brake_timeout`. A timeout of 0 exits on the first tick.
  - If stop detection and timeout occur in the same cycle, stop detection wins and the flag stays clear.
- **Width rules**
  - Slew arithmetic is done at K_PWMRES+1 bits, then saturated to [0, target] or [0, current].
  - `i_param_pwr_level` > 10 is clamped to 10.

## Timing
- **Reset values:** `o_state`=IDLE, `o_pwm_command`=0, `o_pwr_command`=0, `o_brake`=1, `o_reverse`=0, `o_running`=0, `o_speed_time_base`=0, `o_brake_timeout`=0; time-base counter=0.
- **Reset behaviour:** reset is asynchronous. Assertion mid-operation forces all reset values immediately, and there is no drain sequence.
- **Output registration:** all outputs are registered. State and outputs change on the same edge.
- **Slew latency:** a slew step appears on `o_pwm_command` on the same edge that raises `o_speed_time_base`.
- **Time-base period:** with a constant divider, `o_speed_time_base` pulses every `i_param_tb_div`+1 clocks. The first pulse follows the edge that ends clock `i_param_tb_div`+1 after reset release. Divider 0 gives a pulse every cycle.
- **Divider change:** lowering the divider below the current count causes a wrap and tick on the next cycle.
- **Zero target:** IDLE → RAMP_UP → RUN takes 2 cycles minimum, e.g. with target 0.
- **Reversal:** `o_reverse` changes only on IDLE exit, never while pwm ≠ 0.

## Test plan
- **Time base:** div=3 after reset → `o_speed_time_base` pulses at clocks 4, 8, 12; a change to div=0 mid-count → pulse on every following cycle.
- **Ramp up:** step=100, target=350, enable → pwm 0, 100, 200, 300, 350 on successive ticks; `o_running`=1 on the edge where pwm=350. Then target=120 → pwm 250, 150, 120.
- **Reversal:** in RUN at 350, `i_target_reverse`=1 → RAMP_DOWN with pwm 250, 150, 50, 0 → BRAKE, brake=1.
  - Speed 500 (thr 200) → stays in BRAKE.
  - Speed 150 valid → IDLE, then RAMP_UP with `o_reverse`=1.
- **No slew:** step=0, target=700 → pwm 0 → 700 on the first tick; disable → pwm 0 on the next tick → BRAKE.
- **Brake timeout:** timeout=2, no `i_speed_valid` → IDLE after 2 ticks with `o_brake_timeout`=1. The flag holds through IDLE and clears on re-enable.
- **Reset mid-ramp:** assert `i_rst_n`=0 mid-RAMP_UP at pwm 300 → all outputs at reset values before the next clock edge; after release, behaviour resumes from IDLE.

Source files
------------

// File: rtl/motor_sequencer.sv
// Run-state controller in front of motor_control_top. Generates the speed-meter
// time base, slews the PWM command toward its target once per tick, and walks
// every direction change through ramp-down and brake before restarting.
// There is no valid/ready handshake here: i_enable and i_target_* are levels
// sampled every clock, and i_speed is qualified by the one-cycle
// i_speed_valid strobe.
module motor_sequencer #(
    parameter int K_PWMRES   = 10,
    parameter int K_TBDIV    = 16,
    parameter int K_SPDWIDTH = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_target_reverse,
    input  logic [K_PWMRES-1:0]   i_target_pwm,
    input  logic [K_TBDIV-1:0]    i_param_tb_div,
    input  logic [K_PWMRES-1:0]   i_param_ramp_step,
    input  logic [3:0]            i_param_pwr_level,
    input  logic [K_SPDWIDTH-1:0] i_param_stop_thr,
    input  logic [7:0]            i_param_brake_timeout,
    input  logic [K_SPDWIDTH-1:0] i_speed,
    input  logic                  i_speed_valid,
    output logic                  o_speed_time_base,
    output logic [K_PWMRES-1:0]   o_pwm_command,
    output logic [3:0]            o_pwr_command,
    output logic                  o_brake,
    output logic                  o_reverse,
    output logic                  o_running,
    output logic [2:0]            o_state,
    output logic                  o_brake_timeout
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        RUN       = 3'd2,
        RAMP_DOWN = 3'd3,
        BRAKE     = 3'd4
    } state_t;

    localparam int PW1 = K_PWMRES + 1;

    state_t              state, state_n;
    logic [K_TBDIV-1:0]  tb_cnt;
    logic                tick;
    logic [7:0]          brk_cnt, brk_cnt_n;
    logic [K_PWMRES-1:0] pwm_n, pwm_slew, pwm_down;
    logic [3:0]          pwr_n, pwr_lvl;
    logic                brake_n, reverse_n, running_n, timeout_n;
    logic [PW1-1:0]      up_sum, tgt_plus_step;
    logic [8:0]          brk_inc;

    // Tick is asserted combinationally in the cycle the counter wraps.
    assign tick = (tb_cnt >= i_param_tb_div);

    // Time-base counter and registered tick output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tb_cnt            <= '0;
            o_speed_time_base <= 1'b0;
        end else begin
            tb_cnt            <= tick ? '0 : tb_cnt + 1'b1;
            o_speed_time_base <= tick;
        end
    end

    // Slew arithmetic at one extra bit so sums never wrap before saturation.
    always_comb begin
        pwr_lvl       = (i_param_pwr_level > 4'd10) ? 4'd10 : i_param_pwr_level;
        up_sum        = {1'b0, o_pwm_command} + {1'b0, i_param_ramp_step};
        tgt_plus_step = {1'b0, i_target_pwm} + {1'b0, i_param_ramp_step};
        brk_inc       = {1'b0, brk_cnt} + 9'd1;
        pwm_slew      = o_pwm_command;
        if (o_pwm_command < i_target_pwm) begin
            if (i_param_ramp_step == '0 || up_sum >= {1'b0, i_target_pwm})
                pwm_slew = i_target_pwm;
            else
                pwm_slew = up_sum[K_PWMRES-1:0];
        end else if (o_pwm_command > i_target_pwm) begin
            if (i_param_ramp_step == '0 || {1'b0, o_pwm_command} <= tgt_plus_step)
                pwm_slew = i_target_pwm;
            else
                pwm_slew = o_pwm_command - i_param_ramp_step;
        end
        if (i_param_ramp_step == '0 || o_pwm_command <= i_param_ramp_step)
            pwm_down = '0;
        else
            pwm_down = o_pwm_command - i_param_ramp_step;
    end

    // Next-state and next-output logic; outputs follow the state they enter.
    always_comb begin
        state_n   = state;
        pwm_n     = o_pwm_command;
        pwr_n     = o_pwr_command;
        brake_n   = o_brake;
        reverse_n = o_reverse;
        timeout_n = o_brake_timeout;
        brk_cnt_n = brk_cnt;
        case (state)
            IDLE: begin
                pwm_n   = '0;
                pwr_n   = 4'd0;
                brake_n = 1'b1;
                if (i_enable) begin
                    state_n   = RAMP_UP;
                    reverse_n = i_target_reverse;
                    timeout_n = 1'b0;
                    brake_n   = 1'b0;
                    pwr_n     = pwr_lvl;
                end
            end
            RAMP_UP, RUN: begin
                brake_n = 1'b0;
                pwr_n   = pwr_lvl;
                if (!i_enable || (i_target_reverse != o_reverse)) begin
                    // Leaving wins over a slew step in the same cycle.
                    state_n = RAMP_DOWN;
                end else begin
                    if (tick)
                        pwm_n = pwm_slew;
                    if (state == RAMP_UP && pwm_n == i_target_pwm)
                        state_n = RUN;
                end
            end
            RAMP_DOWN: begin
                brake_n = 1'b0;
                pwr_n   = pwr_lvl;
                if (tick)
                    pwm_n = pwm_down;
                if (pwm_n == '0) begin
                    state_n   = BRAKE;
                    brake_n   = 1'b1;
                    pwr_n     = 4'd0;
                    brk_cnt_n = 8'd0;
                end
            end
            BRAKE: begin
                brake_n = 1'b1;
                pwm_n   = '0;
                pwr_n   = 4'd0;
                if (i_speed_valid && (i_speed < i_param_stop_thr)) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (brk_inc >= {1'b0, i_param_brake_timeout}) begin
                        state_n   = IDLE;
                        timeout_n = 1'b1;
                    end else begin
                        brk_cnt_n = brk_inc[7:0];
                    end
                end
            end
            default: begin
                state_n = IDLE;
                pwm_n   = '0;
                pwr_n   = 4'd0;
                brake_n = 1'b1;
            end
        endcase
        running_n = (state_n == RUN);
    end

    // State and output registers, all updated on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            o_pwm_command   <= '0;
            o_pwr_command   <= 4'd0;
            o_brake         <= 1'b1;
            o_reverse       <= 1'b0;
            o_running       <= 1'b0;
            o_brake_timeout <= 1'b0;
            brk_cnt         <= 8'd0;
        end else begin
            state           <= state_n;
            o_pwm_command   <= pwm_n;
            o_pwr_command   <= pwr_n;
            o_brake         <= brake_n;
            o_reverse       <= reverse_n;
            o_running       <= running_n;
            o_brake_timeout <= timeout_n;
            brk_cnt         <= brk_cnt_n;
        end
    end

    assign o_state = state;

endmodule
